// File: rtl/bth_mlt_pkg.sv
// Shared types and defaults for the radix-2 Booth multiplier.
// Holds the controller state encoding and the default operand width.
package bth_mlt_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bth_mlt_booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of M
// into A, then an arithmetic right shift of {A, Q, Q_1}.
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_1_nxt
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    // A is one bit wider than the operands, so replicating its MSB is a true sign extension
    assign a_nxt   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt   = {sum[0], q[WIDTH-1:1]};
    assign q_1_nxt = q[0];

endmodule

// File: rtl/bth_mlt.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, registered
// product with a single-cycle done pulse on completion.
//
// state | meaning
// IDLE  | waiting for load; prod holds the last result
// RUN   | Booth iterations in progress, cnt steps remaining
module bth_mlt
    import bth_mlt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     inp_q,
    input  logic [WIDTH-1:0]     inp_m,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH:0]   a, m, a_step;
    logic [WIDTH-1:0] q, q_step;
    logic             q_1, q_1_step;
    logic [CW-1:0]    cnt;
    logic             last_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a       (a),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .a_nxt   (a_step),
        .q_nxt   (q_step),
        .q_1_nxt (q_1_step)
    );

    assign last_step = (cnt == CW'(1));
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = RUN;
            RUN: begin
                if (load) begin
                    state_nxt = RUN;
                end else if (last_step) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // load wins over an in-flight step, which is what makes restart/abort work
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a    <= '0;
            q    <= '0;
            q_1  <= 1'b0;
            m    <= '0;
            cnt  <= '0;
            prod <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a   <= '0;
                q   <= inp_q;
                q_1 <= 1'b0;
                m   <= {inp_m[WIDTH-1], inp_m};
                cnt <= CW'(WIDTH);
            end else if (state == RUN) begin
                a   <= a_step;
                q   <= q_step;
                q_1 <= q_1_step;
                cnt <= cnt - CW'(1);
                if (last_step) begin
                    prod <= {a_step[WIDTH-1:0], q_step};
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bth_mlt.sv
// Self-checking bench for bth_mlt: cycle-level behavioural model compared
// every cycle, plus directed operations with hand-computed products.
module tb_bth_mlt;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           load = 1'b0;
    logic [W-1:0]   inp_q = '0;
    logic [W-1:0]   inp_m = '0;
    logic [2*W-1:0] prod;
    logic           done;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // model state: operands, steps remaining, expected outputs
    int             mq = 0, mm = 0, mcnt = 0;
    bit             mbusy = 1'b0, mdone = 1'b0;
    logic [2*W-1:0] mprod = '0;

    bth_mlt #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .inp_q (inp_q),
        .inp_m (inp_m),
        .prod  (prod),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // result appears W non-load edges after the last load edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mbusy = 1'b0; mdone = 1'b0; mprod = '0; mcnt = 0;
        end else begin
            mdone = 1'b0;
            if (load) begin
                mq = $signed(inp_q);
                mm = $signed(inp_m);
                mcnt = W;
                mbusy = 1'b1;
            end else if (mbusy) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    mprod = (2*W)'(mq * mm);
                    mdone = 1'b1;
                    mbusy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks += 3;
        if (done !== mdone) begin
            errors++; $display("FAIL model_done: got %b want %b at %0t", done, mdone, $time);
        end
        if (busy !== mbusy) begin
            errors++; $display("FAIL model_busy: got %b want %b at %0t", busy, mbusy, $time);
        end
        if (prod !== mprod) begin
            errors++; $display("FAIL model_prod: got %h want %h at %0t", prod, mprod, $time);
        end
        if (done === 1'b1) done_seen++;
    end

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
    endtask

    // one load edge, then scramble operands to show they are not re-sampled
    task automatic do_load(input logic [W-1:0] q, input logic [W-1:0] m);
        @(negedge clk); #1;
        load = 1'b1; inp_q = q; inp_m = m;
        @(negedge clk); #1;
        load = 1'b0;
        inp_q = W'($urandom); inp_m = W'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no done want done within %0d cycles", name, W + 4);
        end
    endtask

    task automatic op(input logic [W-1:0] q, input logic [W-1:0] m,
                      input logic [2*W-1:0] want, input string name);
        int d0;
        d0 = done_seen;
        do_load(q, m);
        wait_done(name);
        @(negedge clk); #1;
        check_val({name, "_prod"}, int'(prod), int'(want));
        check_val({name, "_busy"}, int'(busy), 0);
        check_val({name, "_done_count"}, done_seen - d0, 1);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        check_val("reset_prod", int'(prod), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_done", int'(done), 0);
        #1 rst = 1'b1;

        op(4'd3, 4'd5, 8'h0F, "p3x5");
        pulse_reset();
        op(4'd4, 4'hD, 8'hF4, "p4xm3");
        op(4'h8, 4'h8, 8'h40, "m8xm8");
        op(4'd7, 4'h8, 8'hC8, "p7xm8");

        // reset mid-operation: no done, prod cleared
        d0 = done_seen;
        do_load(4'd3, 4'd5);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check_val("abort_rst_prod", int'(prod), 0);
        check_val("abort_rst_done", done_seen - d0, 0);
        op(4'd2, 4'hF, 8'hFE, "p2xm1");

        // restart mid-operation: only the second result completes
        d0 = done_seen;
        do_load(4'd3, 4'd5);
        repeat (2) @(posedge clk);
        do_load(4'd6, 4'd6);
        wait_done("restart");
        repeat (3) @(negedge clk);
        #1;
        check_val("restart_prod", int'(prod), 8'h24);
        check_val("restart_done_count", done_seen - d0, 1);

        // load held high: last sampled operands win (-5 * 3 = -15)
        d0 = done_seen;
        @(negedge clk); #1 load = 1'b1; inp_q = 4'd1; inp_m = 4'd1;
        @(negedge clk); #1 inp_q = 4'd2; inp_m = 4'd3;
        @(negedge clk); #1 inp_q = 4'hB; inp_m = 4'd3;
        @(negedge clk); #1 load = 1'b0; inp_q = 4'd7; inp_m = 4'd7;
        wait_done("hold");
        @(negedge clk); #1;
        check_val("hold_prod", int'(prod), 8'hF1);
        check_val("hold_done_count", done_seen - d0, 1);

        for (int qi = -8; qi < 8; qi++) begin
            for (int mi = -8; mi < 8; mi++) begin
                op(W'(qi), W'(mi), (2*W)'(qi * mi), "exh");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish by 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bth_mlt.md
BTH_MLT -- requirements
Module: bth_mlt

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; prod is 2*WIDTH bits.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-low reset.
REQ-005 Port: load  input  1  start request, sampled on the rising clk edge.
REQ-006 Port: inp_q  input  WIDTH  multiplier, two's complement signed.
REQ-007 Port: inp_m  input  WIDTH  multiplicand, two's complement signed.
REQ-008 Port: prod  output  2*WIDTH  signed product, registered.
REQ-009 Port: done  output  1  one-cycle pulse when prod is updated with a new result.
REQ-010 Port: busy  output  1  high while Booth iterations are in progress.

Function
REQ-011 Algorithm: radix-2 Booth, one step per clock; registers A (WIDTH+1 bits), Q (WIDTH), Q_1 (1), M (WIDTH+1, sign-extended inp_m), step counter.
REQ-012 States: IDLE, RUN; IDLE -> RUN on load=1; RUN -> IDLE after the WIDTH-th step.
REQ-013 Load edge (any state): A=0, Q=inp_q, Q_1=0, M=sext(inp_m), counter=WIDTH, busy=1; no Booth step on this edge.
REQ-014 Each RUN edge with load=0: {Q0,Q_1}=01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged; then arithmetic shift right of {A,Q,Q_1} by one (A MSB replicated); counter decremented.
REQ-015 Arithmetic on A is WIDTH+1 bits so inp_m = -2^(WIDTH-1) subtracts without overflow.
REQ-016 Latency: load sampled at edge E0; steps at E1..E(WIDTH); on edge E(WIDTH), prod = low 2*WIDTH bits of {A,Q} after the final shift, done=1 for that cycle, busy=0.
REQ-017 prod holds its last value until the next completion; it does not change during RUN.
REQ-018 Result is the exact signed product for every operand pair, including (-2^(WIDTH-1))*(-2^(WIDTH-1)).
REQ-019 load=1 during RUN aborts the current operation and restarts with the new operands; no done for the aborted one.
REQ-020 Operands are captured only at the load edge; later changes on inp_q/inp_m have no effect.
REQ-021 load held high for several cycles restarts every cycle; iterations begin on the first edge with load=0.

Reset
REQ-022 rst=0 immediately forces: state IDLE, prod=0, done=0, busy=0, A=0, Q=0, Q_1=0, M=0, counter=0.
REQ-023 Reset asserted mid-operation discards it; no done is produced after release.
REQ-024 The first load edge after reset release is honoured normally.

Structure
REQ-025 Shared package bth_mlt_pkg holds the state enum (IDLE, RUN) and the default WIDTH constant.
REQ-026 One combinational sub-module booth_step: inputs A, Q, Q_1, M; outputs next A, Q, Q_1 (add/sub plus arithmetic shift); bth_mlt holds the registers, counter and FSM.

Verification
REQ-027 Reset, load with inp_q=3, inp_m=5 for one edge -> after 4 further edges prod=8'h0F (15), done pulses once, busy low.
REQ-028 Pulse rst low, load with inp_q=4, inp_m=-3 -> after 4 edges prod=8'hF4 (-12).
REQ-029 inp_q=-8, inp_m=-8 -> prod=8'h40 (64); inp_q=7, inp_m=-8 -> prod=8'hC8 (-56).
REQ-030 Load 3*5, assert rst after 2 steps, release -> prod=0, no done; then load 2*-1 -> prod=8'hFE.
REQ-031 Load 3*5, load 6*6 after 2 steps -> single done, prod=8'h24 (36).
REQ-032 Exhaustive: all 256 operand pairs -> prod equals the signed reference product, done exactly once each.
